// File: rtl/rot_dma_seq.sv
// Frame-level transfer sequencer: splits a frame into bursts of up to MAX_BURST words.
// Each chunk is a DMA read into the input buffer, a rotate-core pass, and a DMA write.
module rot_dma_seq #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned WORDS_W   = 16
) (
    input  logic               I_SEQ_HCLK,
    input  logic               I_SEQ_HRESET,
    input  logic               I_SEQ_START,
    input  logic               I_SEQ_ABORT,
    input  logic [31:0]        I_SEQ_SRC_ADDR,
    input  logic [31:0]        I_SEQ_DST_ADDR,
    input  logic [WORDS_W-1:0] I_SEQ_WORDS,
    input  logic               I_SEQ_DMA_DONE,
    input  logic               I_SEQ_CORE_DONE,
    output logic [31:0]        O_SEQ_DMA_ADDR,
    output logic [4:0]         O_SEQ_DMA_COUNT,
    output logic [2:0]         O_SEQ_DMA_SIZE,
    output logic               O_SEQ_DMA_WRITE,
    output logic               O_SEQ_DMA_START,
    output logic               O_SEQ_DMA_STOP,
    output logic               O_SEQ_IMEM_WRITE,
    output logic               O_SEQ_OMEM_WRITE,
    output logic               O_SEQ_CORE_START,
    output logic               O_SEQ_BUSY,
    output logic               O_SEQ_DONE,
    output logic               O_SEQ_ABORTED
);

    localparam int unsigned CNT_W     = 5;
    localparam int unsigned ADDR_W    = 32;
    localparam logic [2:0]  SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_PROC    = 3'd3,
        S_WR_REQ  = 3'd4,
        S_WR_WAIT = 3'd5,
        S_NEXT    = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  src_ptr_q, dst_ptr_q;
    logic [WORDS_W-1:0] rem_q;
    logic [CNT_W-1:0]   chunk_q;

    logic [CNT_W-1:0]   chunk_c;
    logic [WORDS_W-1:0] rem_after_c;
    logic [ADDR_W-1:0]  step_c;
    logic               abort_take_c;

    logic [ADDR_W-1:0]  dma_addr_q, dma_addr_d;
    logic [CNT_W-1:0]   dma_count_q, dma_count_d;
    logic               dma_write_q, dma_write_d;
    logic               dma_start_q, dma_start_d;
    logic               dma_stop_q, dma_stop_d;
    logic               imem_write_q, imem_write_d;
    logic               omem_write_q, omem_write_d;
    logic               core_start_q, core_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic [2:0]         dma_size_q;

    // Chunk sizing and per-chunk advance
    always_comb begin
        if (rem_q >= WORDS_W'(MAX_BURST)) begin
            chunk_c = CNT_W'(MAX_BURST);
        end else begin
            chunk_c = CNT_W'(rem_q);
        end
        rem_after_c  = rem_q - WORDS_W'(chunk_q);
        step_c       = ADDR_W'(chunk_q) << 2;
        abort_take_c = I_SEQ_ABORT && (state_q != S_IDLE);
    end

    // State register
    always_ff @(posedge I_SEQ_HCLK or posedge I_SEQ_HRESET) begin
        if (I_SEQ_HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every completion event
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (I_SEQ_START) begin
                    state_d = (I_SEQ_WORDS != '0) ? S_RD_REQ : S_FIN;
                end
            end
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: if (I_SEQ_DMA_DONE)  state_d = S_PROC;
            S_PROC:    if (I_SEQ_CORE_DONE) state_d = S_WR_REQ;
            S_WR_REQ:  state_d = S_WR_WAIT;
            S_WR_WAIT: if (I_SEQ_DMA_DONE)  state_d = S_NEXT;
            S_NEXT:    state_d = (rem_after_c == '0) ? S_FIN : S_RD_REQ;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_take_c) begin
            state_d = S_IDLE;
        end
    end

    // Output decode; every value lands in a register one cycle later
    always_comb begin
        dma_addr_d   = dma_addr_q;
        dma_count_d  = dma_count_q;
        dma_write_d  = dma_write_q;
        dma_start_d  = 1'b0;
        dma_stop_d   = 1'b0;
        imem_write_d = 1'b0;
        omem_write_d = 1'b0;
        core_start_d = 1'b0;
        busy_d       = (state_q != S_IDLE);
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        if (abort_take_c) begin
            dma_stop_d = 1'b1;
            aborted_d  = 1'b1;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_RD_REQ: begin
                    dma_addr_d  = src_ptr_q;
                    dma_count_d = chunk_c;
                    dma_write_d = 1'b0;
                    dma_start_d = 1'b1;
                end
                S_RD_WAIT: begin
                    imem_write_d = 1'b1;
                    core_start_d = I_SEQ_DMA_DONE;
                end
                S_PROC: omem_write_d = 1'b1;
                S_WR_REQ: begin
                    dma_addr_d  = dst_ptr_q;
                    dma_count_d = chunk_q;
                    dma_write_d = 1'b1;
                    dma_start_d = 1'b1;
                end
                S_FIN:   done_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Frame pointers, remaining count and held chunk size
    always_ff @(posedge I_SEQ_HCLK or posedge I_SEQ_HRESET) begin
        if (I_SEQ_HRESET) begin
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            chunk_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (I_SEQ_START) begin
                        src_ptr_q <= I_SEQ_SRC_ADDR;
                        dst_ptr_q <= I_SEQ_DST_ADDR;
                        rem_q     <= I_SEQ_WORDS;
                    end
                end
                S_RD_REQ: chunk_q <= chunk_c;
                S_NEXT: begin
                    src_ptr_q <= src_ptr_q + step_c;
                    dst_ptr_q <= dst_ptr_q + step_c;
                    rem_q     <= rem_after_c;
                end
                default: ;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge I_SEQ_HCLK or posedge I_SEQ_HRESET) begin
        if (I_SEQ_HRESET) begin
            dma_addr_q   <= '0;
            dma_count_q  <= '0;
            dma_write_q  <= 1'b0;
            dma_start_q  <= 1'b0;
            dma_stop_q   <= 1'b0;
            imem_write_q <= 1'b0;
            omem_write_q <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            dma_size_q   <= SIZE_WORD;
        end else begin
            dma_addr_q   <= dma_addr_d;
            dma_count_q  <= dma_count_d;
            dma_write_q  <= dma_write_d;
            dma_start_q  <= dma_start_d;
            dma_stop_q   <= dma_stop_d;
            imem_write_q <= imem_write_d;
            omem_write_q <= omem_write_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            dma_size_q   <= SIZE_WORD;
        end
    end

    assign O_SEQ_DMA_ADDR   = dma_addr_q;
    assign O_SEQ_DMA_COUNT  = dma_count_q;
    assign O_SEQ_DMA_SIZE   = dma_size_q;
    assign O_SEQ_DMA_WRITE  = dma_write_q;
    assign O_SEQ_DMA_START  = dma_start_q;
    assign O_SEQ_DMA_STOP   = dma_stop_q;
    assign O_SEQ_IMEM_WRITE = imem_write_q;
    assign O_SEQ_OMEM_WRITE = omem_write_q;
    assign O_SEQ_CORE_START = core_start_q;
    assign O_SEQ_BUSY       = busy_q;
    assign O_SEQ_DONE       = done_q;
    assign O_SEQ_ABORTED    = aborted_q;

endmodule
